// File: rtl/exec_unit_seq.sv
// Execute-stage unit: sign-extended immediate operand, registered single-cycle ALU ops,
// and a multi-cycle shift-add multiplier behind a start/busy/done handshake.
module exec_unit_seq #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           alu_control,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 use_imm,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  // Handshake: start is taken on a rising edge only while the FSM is IDLE; operands and
  // alu_control are captured on that edge. busy is high while a multiply is in flight
  // (start is ignored then, not queued). done is a one-cycle pulse after each completion.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             accept;
  logic             is_mul;
  logic             last_step;
  logic [WIDTH-1:0] acc_next;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             done_q;

  generate
    if (IMM_WIDTH == WIDTH) begin : g_no_ext
      assign imm_ext = imm;
    end else begin : g_ext
      assign imm_ext = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    end
  endgenerate

  assign op_b = use_imm ? imm_ext : b;
  assign sum  = a + op_b;
  assign diff = a - op_b;
  // True signed compare; the sign of the difference is wrong whenever the subtraction overflows.
  assign slt  = $signed(a) < $signed(op_b);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_control)
      3'b000: alu_res = a & op_b;
      3'b001: alu_res = a | op_b;
      3'b010: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b110: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b111:  alu_res = WIDTH'(slt);
      default: alu_res = '0;
    endcase
  end

  assign accept    = start && (state_q == S_IDLE);
  assign is_mul    = (alu_control == 3'b011);
  assign last_step = (count_q == '0);
  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_MUL);
    zero = (result_q == '0);
  end

  // One multiplier bit per cycle; the final step's sum is written straight to result.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand_q  <= a;
          mplier_q <= op_b;
          acc_q    <= '0;
          count_q  <= LAST_COUNT;
        end else begin
          result_q   <= alu_res;
          overflow_q <= alu_ovf;
          done_q     <= 1'b1;
        end
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (last_step) begin
          result_q   <= acc_next;
          overflow_q <= 1'b0;
          done_q     <= 1'b1;
        end else begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_exec_unit_seq.sv
// Bench for exec_unit_seq: three parameterisations (32/16, 8/8, 16/4) driven by scenario
// tasks and randomized ops, checked against an arithmetic reference model.
module tb_exec_unit_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // u0: WIDTH=32 IMM_WIDTH=16
  logic        start0, ui0, zero0, ovf0, busy0, done0;
  logic [2:0]  op0;
  logic [31:0] a0, b0, res0;
  logic [15:0] imm0;
  // u1: WIDTH=8 IMM_WIDTH=8
  logic        start1, ui1, zero1, ovf1, busy1, done1;
  logic [2:0]  op1;
  logic [7:0]  a1, b1, res1, imm1;
  // u2: WIDTH=16 IMM_WIDTH=4
  logic        start2, ui2, zero2, ovf2, busy2, done2;
  logic [2:0]  op2;
  logic [15:0] a2, b2, res2;
  logic [3:0]  imm2;

  exec_unit_seq #(.WIDTH(32), .IMM_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .start(start0), .alu_control(op0), .a(a0), .b(b0),
    .imm(imm0), .use_imm(ui0), .result(res0), .zero(zero0), .overflow(ovf0),
    .busy(busy0), .done(done0));
  exec_unit_seq #(.WIDTH(8), .IMM_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .start(start1), .alu_control(op1), .a(a1), .b(b1),
    .imm(imm1), .use_imm(ui1), .result(res1), .zero(zero1), .overflow(ovf1),
    .busy(busy1), .done(done1));
  exec_unit_seq #(.WIDTH(16), .IMM_WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .start(start2), .alu_control(op2), .a(a2), .b(b2),
    .imm(imm2), .use_imm(ui2), .result(res2), .zero(zero2), .overflow(ovf2),
    .busy(busy2), .done(done2));

  logic [31:0] res_v [3];
  logic        zero_v[3], ovf_v[3], busy_v[3], done_v[3];
  always_comb begin
    res_v[0] = res0;        zero_v[0] = zero0; ovf_v[0] = ovf0; busy_v[0] = busy0; done_v[0] = done0;
    res_v[1] = 32'(res1);   zero_v[1] = zero1; ovf_v[1] = ovf1; busy_v[1] = busy1; done_v[1] = done1;
    res_v[2] = 32'(res2);   zero_v[2] = zero2; ovf_v[2] = ovf2; busy_v[2] = busy2; done_v[2] = done2;
  end

  function automatic int wid(int u);
    return (u == 0) ? 32 : (u == 1) ? 8 : 16;
  endfunction
  function automatic int iwid(int u);
    return (u == 0) ? 16 : (u == 1) ? 8 : 4;
  endfunction

  // Reference model: operands as plain signed/unsigned integers of the chosen width.
  function automatic logic [31:0] model(int w, int iw, logic [2:0] op, logic [31:0] av,
                                        logic [31:0] bv, logic [15:0] iv, logic ui,
                                        output logic ovf);
    longint m, ua, ub, sa, sb, s, si, r, lo, hi;
    m  = (longint'(1) << w) - 1;
    ua = longint'(av) & m;
    if (ui) begin
      si = longint'(iv) & ((longint'(1) << iw) - 1);
      if (si >= (longint'(1) << (iw - 1))) si = si - (longint'(1) << iw);
      ub = si & m;
    end else begin
      ub = longint'(bv) & m;
    end
    sa  = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb  = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    ovf = 1'b0;
    r   = 0;
    case (op)
      3'b000: r = ua & ub;
      3'b001: r = ua | ub;
      3'b010: begin s = sa + sb; ovf = (s > hi) || (s < lo); r = (ua + ub) & m; end
      3'b110: begin s = sa - sb; ovf = (s > hi) || (s < lo); r = (ua - ub) & m; end
      3'b111: r = (sa < sb) ? 1 : 0;
      3'b011: r = (ua * ub) & m;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  task automatic set_in(int u, logic st, logic [2:0] op, logic [31:0] av, logic [31:0] bv,
                        logic [15:0] iv, logic ui);
    case (u)
      0: begin start0 = st; op0 = op; a0 = av; b0 = bv; imm0 = iv; ui0 = ui; end
      1: begin start1 = st; op1 = op; a1 = av[7:0]; b1 = bv[7:0]; imm1 = iv[7:0]; ui1 = ui; end
      default: begin start2 = st; op2 = op; a2 = av[15:0]; b2 = bv[15:0]; imm2 = iv[3:0]; ui2 = ui; end
    endcase
  endtask

  task automatic set_start(int u, logic st);
    case (u)
      0: start0 = st;
      1: start1 = st;
      default: start2 = st;
    endcase
  endtask

  // Issue one op and follow it to completion; entered and left at #1 after a rising edge.
  task automatic run_op(int u, logic [2:0] op, logic [31:0] av, logic [31:0] bv,
                        logic [15:0] iv, logic ui, bit scr, bit hold, string tag);
    logic [31:0] exp_r, prev;
    logic        exp_o;
    int          lat, cyc, bcnt;
    bit          held_ok;
    exp_r   = model(wid(u), iwid(u), op, av, bv, iv, ui, exp_o);
    lat     = (op == 3'b011) ? wid(u) : 0;
    prev    = res_v[u];
    held_ok = 1'b1;
    set_in(u, 1'b1, op, av, bv, iv, ui);
    @(posedge clk); #1;
    if (scr) set_in(u, hold, 3'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom),
                    1'($urandom_range(0, 1)));
    else     set_start(u, hold);
    cyc  = 0;
    bcnt = 0;
    while (!done_v[u] && cyc < 100) begin
      if (busy_v[u]) bcnt++;
      if (res_v[u] !== prev) held_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    set_start(u, 1'b0);
    n_vec++;
    if (cyc !== lat) begin
      n_err++; $display("FAIL %s done_latency u%0d: got %0d want %0d", tag, u, cyc, lat);
    end
    n_vec++;
    if (bcnt !== lat) begin
      n_err++; $display("FAIL %s busy_cycles u%0d: got %0d want %0d", tag, u, bcnt, lat);
    end
    n_vec++;
    if (res_v[u] !== exp_r || zero_v[u] !== (exp_r == 0) || ovf_v[u] !== exp_o) begin
      n_err++;
      $display("FAIL %s result u%0d: got %h z%b v%b want %h z%b v%b", tag, u, res_v[u],
               zero_v[u], ovf_v[u], exp_r, exp_r == 0, exp_o);
    end
    if (lat > 0) begin
      n_vec++;
      if (!held_ok) begin
        n_err++; $display("FAIL %s result_hold u%0d: got changed want %h", tag, u, prev);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || res_v[u] !== exp_r) begin
      n_err++;
      $display("FAIL %s after_done u%0d: got d%b b%b %h want d0 b0 %h", tag, u, done_v[u],
               busy_v[u], res_v[u], exp_r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 3; u++) set_in(u, 1'b0, 3'b000, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      n_vec++;
      if (res_v[u] !== 0 || zero_v[u] !== 1'b1 || ovf_v[u] !== 1'b0 || busy_v[u] !== 1'b0
          || done_v[u] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state u%0d: got %h z%b v%b b%b d%b want 0 z1 v0 b0 d0", u,
                 res_v[u], zero_v[u], ovf_v[u], busy_v[u], done_v[u]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_sign_ext_add();
    run_op(0, 3'b010, 32'h0000_8000, 32'h0, 16'h8000, 1'b1, 1'b0, 1'b0, "sext_add");
  endtask

  task automatic test_overflow_slt();
    run_op(0, 3'b010, 32'h7FFF_FFFF, 32'h1, 16'h0, 1'b0, 1'b0, 1'b0, "add_ovf");
    run_op(0, 3'b111, 32'h8000_0000, 32'h1, 16'h0, 1'b0, 1'b0, 1'b0, "slt_neg");
    run_op(0, 3'b111, 32'h5, 32'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "slt_imm");
  endtask

  task automatic test_mul();
    run_op(0, 3'b011, 32'd1234, 32'd5678, 16'h0, 1'b0, 1'b1, 1'b0, "mul_latency");
    run_op(0, 3'b011, 32'hFFFF_FFFF, 32'h0, 16'h0003, 1'b1, 1'b0, 1'b1, "mul_wrap");
  endtask

  task automatic test_reset_mid_mul();
    int dcnt;
    set_in(0, 1'b1, 3'b011, $urandom | 32'h1, $urandom | 32'h1, 16'h0, 1'b0);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    n_vec++;
    if (busy_v[0] !== 1'b1) begin
      n_err++; $display("FAIL midmul_busy: got %b want 1", busy_v[0]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (res_v[0] !== 0 || zero_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midmul_reset: got %h z%b b%b d%b want 0 z1 b0 d0", res_v[0], zero_v[0],
               busy_v[0], done_v[0]);
    end
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done_v[0]) dcnt++; end
    n_vec++;
    if (dcnt !== 0) begin
      n_err++; $display("FAIL midmul_no_done: got %0d pulses want 0", dcnt);
    end
    run_op(0, 3'b000, 32'hF0F0, 32'h0FF0, 16'h0, 1'b0, 1'b0, 1'b0, "and_after_reset");
  endtask

  task automatic test_param_sweep();
    run_op(2, 3'b001, 32'h0, 32'h0, 16'h0008, 1'b1, 1'b0, 1'b0, "sweep_or_imm4");
    run_op(1, 3'b011, 32'd15, 32'd17, 16'h0, 1'b0, 1'b0, 1'b0, "sweep_mul8");
    run_op(2, 3'b101, 32'h1234, 32'h5678, 16'h0, 1'b0, 1'b0, 1'b0, "sweep_rsv16");
    run_op(1, 3'b100, 32'h7F, 32'h01, 16'h0, 1'b0, 1'b0, 1'b0, "sweep_rsv8");
  endtask

  task automatic test_back_to_back();
    logic [31:0] av, bv, e1, e2, e3;
    logic        o1, o2, o3;
    int          cyc;
    av = $urandom; bv = $urandom;
    e1 = model(32, 16, 3'b010, av, bv, 16'h0, 1'b0, o1);
    e2 = model(32, 16, 3'b110, bv, av, 16'h0, 1'b0, o2);
    e3 = model(32, 16, 3'b011, av, bv, 16'h0, 1'b0, o3);
    set_in(0, 1'b1, 3'b010, av, bv, 16'h0, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (done_v[0] !== 1'b1 || res_v[0] !== e1 || ovf_v[0] !== o1) begin
      n_err++; $display("FAIL b2b_add: got d%b %h v%b want d1 %h v%b", done_v[0], res_v[0],
                        ovf_v[0], e1, o1);
    end
    set_in(0, 1'b1, 3'b110, bv, av, 16'h0, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (done_v[0] !== 1'b1 || res_v[0] !== e2 || ovf_v[0] !== o2) begin
      n_err++; $display("FAIL b2b_sub: got d%b %h v%b want d1 %h v%b", done_v[0], res_v[0],
                        ovf_v[0], e2, o2);
    end
    set_in(0, 1'b1, 3'b011, av, bv, 16'h0, 1'b0);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    n_vec++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_err++; $display("FAIL b2b_mul_start: got b%b d%b want b1 d0", busy_v[0], done_v[0]);
    end
    cyc = 0;
    while (!done_v[0] && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (cyc !== 32 || res_v[0] !== e3 || ovf_v[0] !== 1'b0) begin
      n_err++; $display("FAIL b2b_mul: got %h after %0d v%b want %h after 32 v0", res_v[0],
                        cyc, ovf_v[0], e3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int u = 0; u < 3; u++) begin
      repeat (15) begin
        op = 3'($urandom_range(0, 7));
        run_op(u, op, $urandom, $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_sign_ext_add();
    test_overflow_slt();
    test_mul();
    test_reset_mid_mul();
    test_param_sweep();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
